// File: rtl/div_iter.sv
// Multicycle signed restoring divider, one quotient bit per clock, start/ready handshake.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module div_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             result_rdy,
  output logic             exception,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] counter;
  logic             sign_q;
  logic             zero_div;
  logic             ovf;
`ifdef DIV_REMAINDER_EN
  logic             sign_r;
`endif

  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;

  assign dividend_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign divisor_abs  = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The partial remainder stays below D <= 2^(WIDTH-1), so r_shift < 2^WIDTH and
  // the top bit of the WIDTH+1 bit difference is a reliable sign.
  assign r_shift = {r, q[WIDTH-1]};
  assign diff    = r_shift - {1'b0, d};

  // NOTE: every register in this block uses <= so all of them update from the
  // values present before the edge; the reset branch is synchronous by design.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      r          <= '0;
      q          <= '0;
      d          <= '0;
      counter    <= '0;
      sign_q     <= 1'b0;
      zero_div   <= 1'b0;
      ovf        <= 1'b0;
      quotient   <= '0;
      result_rdy <= 1'b0;
      exception  <= 1'b0;
      busy       <= 1'b0;
`ifdef DIV_REMAINDER_EN
      sign_r     <= 1'b0;
      remainder  <= '0;
`endif
    end else begin
      result_rdy <= 1'b0;

      // Publishing takes priority over the exception clear of a start in DONE.
      if (state == DONE) begin
        quotient   <= zero_div ? '0 : (sign_q ? -q : q);
        exception  <= zero_div | ovf;
        result_rdy <= 1'b1;
`ifdef DIV_REMAINDER_EN
        remainder  <= (zero_div | ovf) ? '0 : (sign_r ? -r : r);
`endif
      end else if (ctrl_div) begin
        exception <= 1'b0;
      end

      if (ctrl_div) begin
        r        <= '0;
        q        <= dividend_abs;
        d        <= divisor_abs;
        counter  <= '0;
        sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
        zero_div <= (divisor == '0);
        ovf      <= (dividend == MIN_VAL) && (divisor == '1);
`ifdef DIV_REMAINDER_EN
        sign_r   <= dividend[WIDTH-1];
`endif
        if (divisor == '0) begin
          state <= DONE;
          busy  <= 1'b0;
        end else begin
          state <= CALC;
          busy  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          CALC: begin
            if (!diff[WIDTH]) begin
              r <= diff[WIDTH-1:0];
            end else begin
              r <= r_shift[WIDTH-1:0];
            end
            q       <= {q[WIDTH-2:0], ~diff[WIDTH]};
            counter <= counter + CNT_W'(1);
            if (counter == CNT_W'(WIDTH - 1)) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
